mem_rsp_pipe: RTL

Multi-channel, parametrised response-path cut chain for the memory island. It places NumCuts register stages on each of NumChannels independent rvalid/rready/rdata response streams. Each stage is selectable as a full spill cut (breaks valid, data and ready) or a half pipe cut (breaks valid and data only). It adds per-channel occupancy reporting and a synchronous flush, and sits between bank response ports and the interconnect return path.

---
 rtl/mem_rsp_pkg.sv | 22 ++
 rtl/mem_rsp_cut_stage.sv | 113 +++++++++++
 rtl/mem_rsp_pipe.sv | 82 ++++++++
 3 files changed

// File: rtl/mem_rsp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_rsp_pkg : shared types and sizing helpers for the response cut chain
// Revision    : 1.0
// ----------------------------------------------------------------------------
package mem_rsp_pkg;

  typedef enum logic {
    CutSpill = 1'b0,
    CutPipe  = 1'b1
  } cut_mode_e;

  // Occupancy port is sized for two slots per stage in either mode, so the
  // port width does not change when a block switches cut type.
  function automatic int occ_width(input int num_cuts, input cut_mode_e mode);
    int w;
    w = $clog2(2 * num_cuts + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rsp_cut_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_rsp_cut_stage : one valid/ready register stage, spill (2-slot) or pipe
// Revision          : 1.0
// ----------------------------------------------------------------------------
module mem_rsp_cut_stage
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter cut_mode_e   CutMode   = CutSpill
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [1:0]           occ_o
);

  if (CutMode == CutSpill) begin : g_spill
    logic                 a_full_q, a_full_d, b_full_q, b_full_d;
    logic [DataWidth-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic                 w_in_fire, w_out_fire;

    assign valid_o    = a_full_q & ~flush_i;
    assign ready_o    = ~b_full_q & ~flush_i;
    assign data_o     = a_data_q;
    assign w_in_fire  = valid_i & ready_o;
    assign w_out_fire = valid_o & ready_i;
    assign occ_o      = {1'b0, a_full_q} + {1'b0, b_full_q};

    // B can only be full while ready_o is low, so a refill of A from B never
    // coincides with a new beat arriving.
    always_comb begin
      a_full_d = a_full_q;
      b_full_d = b_full_q;
      a_data_d = a_data_q;
      b_data_d = b_data_q;
      if (w_out_fire) begin
        if (b_full_q) begin
          a_data_d = b_data_q;
          b_full_d = 1'b0;
        end else begin
          a_full_d = w_in_fire;
          a_data_d = data_i;
        end
      end else if (w_in_fire) begin
        if (!a_full_q) begin
          a_full_d = 1'b1;
          a_data_d = data_i;
        end else begin
          b_full_d = 1'b1;
          b_data_d = data_i;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
      end else begin
        a_full_q <= a_full_d;
        b_full_q <= b_full_d;
      end
    end

    always_ff @(posedge clk_i) begin
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
    end
  end else begin : g_pipe
    logic                 full_q, full_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 w_in_fire, w_out_fire;

    assign valid_o    = full_q & ~flush_i;
    assign ready_o    = (~full_q | ready_i) & ~flush_i;
    assign data_o     = data_q;
    assign w_in_fire  = valid_i & ready_o;
    assign w_out_fire = valid_o & ready_i;
    assign occ_o      = {1'b0, full_q};

    always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (w_in_fire) begin
        full_d = 1'b1;
        data_d = data_i;
      end else if (w_out_fire) begin
        full_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        full_q <= 1'b0;
      end else begin
        full_q <= full_d;
      end
    end

    always_ff @(posedge clk_i) begin
      data_q <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_rsp_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_rsp_pipe : multi-channel response cut chain with occupancy and flush
// Revision     : 1.0
// ----------------------------------------------------------------------------
module mem_rsp_pipe
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumChannels = 1,
  parameter int unsigned NumCuts     = 1,
  parameter cut_mode_e   CutMode     = CutSpill,
  localparam int         OccW        = occ_width(NumCuts, CutMode)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [NumChannels-1:0]                rvalid_i,
  output logic [NumChannels-1:0]                rready_o,
  input  logic [NumChannels-1:0][DataWidth-1:0] rdata_i,
  output logic [NumChannels-1:0]                rvalid_o,
  input  logic [NumChannels-1:0]                rready_i,
  output logic [NumChannels-1:0][DataWidth-1:0] rdata_o,
  output logic [NumChannels-1:0][OccW-1:0]      occ_o,
  output logic [NumChannels-1:0]                empty_o
);

  if (NumCuts == 0) begin : g_passthru
    logic w_unused_ctrl;
    assign rvalid_o      = rvalid_i;
    assign rready_o      = rready_i;
    assign rdata_o       = rdata_i;
    assign occ_o         = '0;
    assign empty_o       = '1;
    assign w_unused_ctrl = ^{clk_i, rst_i, flush_i};
  end else begin : g_cuts
    for (genvar ch = 0; ch < NumChannels; ch++) begin : g_chan
      logic [NumCuts:0]                w_valid, w_ready;
      logic [NumCuts:0][DataWidth-1:0] w_data;
      logic [NumCuts-1:0][1:0]         w_stage_occ;
      logic [OccW-1:0]                 w_occ_sum;

      assign w_valid[0]       = rvalid_i[ch];
      assign w_data[0]        = rdata_i[ch];
      assign rready_o[ch]     = w_ready[0];
      assign rvalid_o[ch]     = w_valid[NumCuts];
      assign rdata_o[ch]      = w_data[NumCuts];
      assign w_ready[NumCuts] = rready_i[ch];

      for (genvar s = 0; s < NumCuts; s++) begin : g_stage
        mem_rsp_cut_stage #(
          .DataWidth (DataWidth),
          .CutMode   (CutMode)
        ) u_stage (
          .clk_i   (clk_i),
          .rst_i   (rst_i),
          .flush_i (flush_i),
          .valid_i (w_valid[s]),
          .ready_o (w_ready[s]),
          .data_i  (w_data[s]),
          .valid_o (w_valid[s+1]),
          .ready_i (w_ready[s+1]),
          .data_o  (w_data[s+1]),
          .occ_o   (w_stage_occ[s])
        );
      end

      // Occupancy is the sum of registered slot flags, never a separate count.
      always_comb begin
        w_occ_sum = '0;
        for (int s = 0; s < NumCuts; s++) begin
          w_occ_sum = w_occ_sum + OccW'(w_stage_occ[s]);
        end
      end

      assign occ_o[ch]   = w_occ_sum;
      assign empty_o[ch] = (w_occ_sum == '0);
    end
  end

endmodule
`default_nettype wire
